tetromino_collision_checker: RTL and testbench

//   Upstream neighbour of tetromino_drawer. Given a candidate position and

---
 rtl/tetris_pkg.sv | 43 ++++
 rtl/tetromino_collision_checker_ctrl.sv | 65 ++++++
 rtl/tetromino_collision_checker_data.sv | 88 ++++++++
 rtl/tetromino_collision_checker.sv | 75 +++++++
 tb/tb_tetromino_collision_checker.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg
//   Definitions shared by tetromino_drawer and tetromino_collision_checker:
//   default board size, piece ids, checker FSM states, and the 4x4 footprint
//   masks. Mask bit index = dy*4 + dx.
package tetris_pkg;

    localparam int unsigned BOARD_W_DEFAULT = 10;
    localparam int unsigned BOARD_H_DEFAULT = 20;

    typedef enum logic [2:0] {
        EMPTY = 3'd0,
        I     = 3'd1,
        O     = 3'd2,
        T     = 3'd3,
        S     = 3'd4,
        Z     = 3'd5,
        J     = 3'd6,
        L     = 3'd7
    } t_id_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } chk_state_e;

    function automatic logic [15:0] shape_mask(input t_id_e id);
        logic [15:0] m;
        case (id)
            I:       m = 16'h000F;
            O:       m = 16'h0033;
            T:       m = 16'h0027;
            S:       m = 16'h0036;
            Z:       m = 16'h0063;
            J:       m = 16'h0071;
            L:       m = 16'h0074;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tetromino_collision_checker_ctrl.sv
// tetromino_collision_checker_ctrl
//   Sequencer for the collision check: IDLE -> SCAN (16 cells) -> DRAIN ->
//   DONE -> IDLE.
//   Ports:
//     clk, reset  clock, asynchronous active-high reset
//     start       level request, sampled only in IDLE
//     k_eq_15     cell counter is on its last cell
//     load_regs   latch inputs, clear counter and collide flag
//     incr_k      SCAN active: evaluate current cell, advance counter
//     done        one-cycle end-of-check pulse
module tetromino_collision_checker_ctrl
    import tetris_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic k_eq_15,
    output logic load_regs,
    output logic incr_k,
    output logic done
);

    chk_state_e state, state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_regs  = 1'b0;
        incr_k     = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_regs  = 1'b1;
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                incr_k = 1'b1;
                if (k_eq_15) begin
                    state_next = ST_DRAIN;
                end
            end
            // Waits out the return of a read issued on the last cell.
            ST_DRAIN: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/tetromino_collision_checker_data.sv
// tetromino_collision_checker_data
//   Datapath for the collision check: latched position and mask, cell
//   counter k, off-board compare, read-pending flag and sticky collide flag.
//   Ports:
//     clk, reset       clock, asynchronous active-high reset
//     load_regs        latch in_x/in_y/mask, clear k and collide
//     incr_k           evaluate cell k this cycle and advance k
//     in_x, in_y, t_id candidate position and piece id
//     rd_id            board cell contents, one cycle after rd_en
//     k_eq_15          counter is on its last cell
//     rd_x, rd_y       board read address (zero when no read)
//     rd_en            board read strobe
//     collide          accumulated collision result
module tetromino_collision_checker_data
    import tetris_pkg::*;
#(
    parameter int unsigned BOARD_W = BOARD_W_DEFAULT,
    parameter int unsigned BOARD_H = BOARD_H_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_regs,
    input  logic       incr_k,
    input  logic [4:0] in_x,
    input  logic [4:0] in_y,
    input  logic [2:0] t_id,
    input  logic [2:0] rd_id,
    output logic       k_eq_15,
    output logic [4:0] rd_x,
    output logic [4:0] rd_y,
    output logic       rd_en,
    output logic       collide
);

    localparam logic [5:0] W6 = 6'(BOARD_W);
    localparam logic [5:0] H6 = 6'(BOARD_H);

    logic [4:0]  lat_x;
    logic [4:0]  lat_y;
    logic [15:0] mask;
    logic [3:0]  k;
    logic        pending;
    logic [5:0]  bx;
    logic [5:0]  by;
    logic        cell_on;
    logic        off_board;

    // 6-bit sums so a footprint hanging past column/row 31 cannot wrap back
    // onto the board.
    assign bx        = {1'b0, lat_x} + {4'b0, k[1:0]};
    assign by        = {1'b0, lat_y} + {4'b0, k[3:2]};
    assign cell_on   = mask[k];
    assign off_board = (bx >= W6) || (by >= H6);
    assign k_eq_15   = (k == 4'd15);

    assign rd_en = incr_k & cell_on & ~off_board;
    assign rd_x  = rd_en ? bx[4:0] : '0;
    assign rd_y  = rd_en ? by[4:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_x   <= '0;
            lat_y   <= '0;
            mask    <= '0;
            k       <= '0;
            pending <= 1'b0;
            collide <= 1'b0;
        end else begin
            pending <= rd_en;
            if (load_regs) begin
                lat_x   <= in_x;
                lat_y   <= in_y;
                mask    <= shape_mask(t_id_e'(t_id));
                k       <= '0;
                collide <= 1'b0;
            end else begin
                if (incr_k) begin
                    k <= k + 4'd1;
                end
                if ((incr_k && cell_on && off_board) ||
                    (pending && (rd_id != '0))) begin
                    collide <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tetromino_collision_checker.sv
// tetromino_collision_checker
//   Scans a tetromino's 4x4 footprint at a candidate position against the
//   board RAM and reports whether any occupied cell is off-board or lands on
//   a non-empty board cell. Fixed 18-cycle latency from accepted start to
//   done.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     start        level request, sampled only when idle
//     in_x, in_y   candidate top-left column/row
//     t_id         piece id 1..7, 0 = no piece
//     rd_x, rd_y   board RAM read address
//     rd_en        board RAM read strobe
//     rd_id        board cell contents, one cycle after rd_en; 0 = empty
//     collide      result, valid with done and held until the next start
//     done         one-cycle end-of-check pulse
module tetromino_collision_checker
    import tetris_pkg::*;
#(
    parameter int unsigned BOARD_W = BOARD_W_DEFAULT,
    parameter int unsigned BOARD_H = BOARD_H_DEFAULT,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] in_x,
    input  logic [4:0] in_y,
    input  logic [2:0] t_id,
    output logic [4:0] rd_x,
    output logic [4:0] rd_y,
    output logic       rd_en,
    input  logic [2:0] rd_id,
    output logic       collide,
    output logic       done
);

    // The pending flag and single DRAIN cycle assume a one-cycle RAM.
    if (RD_LAT != 1) begin : g_rd_lat_check
        $error("tetromino_collision_checker supports RD_LAT=1 only");
    end

    logic load_regs;
    logic incr_k;
    logic k_eq_15;

    tetromino_collision_checker_ctrl u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .k_eq_15   (k_eq_15),
        .load_regs (load_regs),
        .incr_k    (incr_k),
        .done      (done)
    );

    tetromino_collision_checker_data #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H)
    ) u_data (
        .clk       (clk),
        .reset     (reset),
        .load_regs (load_regs),
        .incr_k    (incr_k),
        .in_x      (in_x),
        .in_y      (in_y),
        .t_id      (t_id),
        .rd_id     (rd_id),
        .k_eq_15   (k_eq_15),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_en     (rd_en),
        .collide   (collide)
    );

endmodule

// File: tb/tb_tetromino_collision_checker.sv
// tb_tetromino_collision_checker
//   Scoreboard bench: each accepted start pushes the expected collide value,
//   done edge and read list; a monitor pops and compares on every done.
module tb_tetromino_collision_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] in_x;
    logic [4:0] in_y;
    logic [2:0] t_id;
    logic [4:0] rd_x;
    logic [4:0] rd_y;
    logic       rd_en;
    logic [2:0] rd_id;
    logic       collide;
    logic       done;

    typedef struct {
        logic         collide;
        int unsigned  done_edge;
        int unsigned  nreads;
        logic [159:0] reads;   // read i at bits [i*10 +: 10] = {x,y}
    } exp_t;

    exp_t        exp_q[$];
    logic [9:0]  got_reads[$];
    logic [2:0]  board[0:31][0:31];
    int unsigned edge_cnt = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    tetromino_collision_checker #(
        .BOARD_W (10),
        .BOARD_H (20),
        .RD_LAT  (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_x    (in_x),
        .in_y    (in_y),
        .t_id    (t_id),
        .rd_x    (rd_x),
        .rd_y    (rd_y),
        .rd_en   (rd_en),
        .rd_id   (rd_id),
        .collide (collide),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt <= edge_cnt + 1;
        end
    end

    // One-cycle board RAM; output holds its last value when not read.
    initial begin
        rd_id = '0;
        forever begin
            @(posedge clk);
            if (rd_en) rd_id <= board[rd_y][rd_x];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] pk(input int unsigned x, input int unsigned y);
        return {5'(x), 5'(y)};
    endfunction

    // Monitor: logs reads and scores each done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                got_reads.delete();
            end else begin
                if (rd_en) got_reads.push_back({rd_x, rd_y});
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_edge", edge_cnt, e.done_edge);
                        chk("collide", {31'b0, collide}, {31'b0, e.collide});
                        chk("read_count", got_reads.size(), e.nreads);
                        for (int i = 0; i < got_reads.size() && i < int'(e.nreads); i++)
                            chk("read_addr", {22'b0, got_reads[i]}, {22'b0, e.reads[i*10 +: 10]});
                        got_reads.delete();
                    end
                end
            end
        end
    end

    task automatic wait_done();
        int unsigned t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Issues one check (DUT must be idle) and waits for its result. With
    // spurious set, a second start is pulsed mid-scan and must be ignored.
    task automatic do_check(input int unsigned x, input int unsigned y, input int unsigned id,
                            input logic c, input int unsigned n, input logic [159:0] r,
                            input logic spurious);
        exp_t e;
        in_x  = 5'(x);
        in_y  = 5'(y);
        t_id  = 3'(id);
        start = 1'b1;
        @(posedge clk);
        e.collide   = c;
        e.done_edge = edge_cnt + 18;
        e.nreads    = n;
        e.reads     = r;
        exp_q.push_back(e);
        #1;
        start = 1'b0;
        in_x  = ~in_x;
        in_y  = ~in_y;
        t_id  = ~t_id;
        if (spurious) begin
            repeat (5) @(posedge clk);
            #1;
            in_x  = '0;
            in_y  = '0;
            t_id  = 3'd1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        exp_t e;
        int unsigned v;
        reset = 1'b1;
        start = 1'b0;
        in_x  = '0;
        in_y  = '0;
        t_id  = '0;
        for (int yy = 0; yy < 32; yy++)
            for (int xx = 0; xx < 32; xx++)
                board[yy][xx] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_x", {27'b0, rd_x}, 32'd0);
        chk("reset_rd_y", {27'b0, rd_y}, 32'd0);
        chk("reset_rd_en", {31'b0, rd_en}, 32'd0);
        chk("reset_collide", {31'b0, collide}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // I at (6,0): fits exactly against the right wall.
        do_check(6, 0, 1, 1'b0, 4, 160'({pk(9,0), pk(8,0), pk(7,0), pk(6,0)}), 1'b0);
        // I at (7,0): column 10 off-board.
        do_check(7, 0, 1, 1'b1, 3, 160'({pk(9,0), pk(8,0), pk(7,0)}), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("collide_held", {31'b0, collide}, 32'd1);

        // O at (4,18) over an occupied (5,19), then the same with it cleared.
        board[19][5] = 3'd2;
        do_check(4, 18, 2, 1'b1, 4, 160'({pk(5,19), pk(4,19), pk(5,18), pk(4,18)}), 1'b0);
        board[19][5] = 3'd0;
        do_check(4, 18, 2, 1'b0, 4, 160'({pk(5,19), pk(4,19), pk(5,18), pk(4,18)}), 1'b0);

        // O at (4,19): row 20 off-board.
        do_check(4, 19, 2, 1'b1, 2, 160'({pk(5,19), pk(4,19)}), 1'b0);

        // S at (0,0): occupied (0,0) lies in an unmasked footprint cell.
        board[0][0] = 3'd3;
        do_check(0, 0, 4, 1'b0, 4, 160'({pk(1,1), pk(0,1), pk(2,0), pk(1,0)}), 1'b0);
        board[0][0] = 3'd0;

        // T at (8,0): (10,0) off-board, other cells still read.
        do_check(8, 0, 3, 1'b1, 3, 160'({pk(9,1), pk(9,0), pk(8,0)}), 1'b0);

        // Z at (2,3) with its last read cell (4,4) occupied.
        board[4][4] = 3'd5;
        do_check(2, 3, 5, 1'b1, 4, 160'({pk(4,4), pk(3,4), pk(3,3), pk(2,3)}), 1'b0);
        board[4][4] = 3'd0;

        // L at (7,17) on an empty board.
        do_check(7, 17, 7, 1'b0, 4, 160'({pk(9,18), pk(8,18), pk(7,18), pk(9,17)}), 1'b0);

        // Empty piece at (31,31), with a start pulsed during the scan.
        do_check(31, 31, 0, 1'b0, 0, '0, 1'b1);

        // start held high: second check starts the cycle after DONE.
        in_x  = '0;
        in_y  = '0;
        t_id  = 3'd1;
        start = 1'b1;
        @(posedge clk);
        v = edge_cnt;
        e.collide = 1'b0;
        e.nreads  = 4;
        e.reads   = 160'({pk(3,0), pk(2,0), pk(1,0), pk(0,0)});
        e.done_edge = v + 18;
        exp_q.push_back(e);
        e.done_edge = v + 37;
        exp_q.push_back(e);
        repeat (20) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // Reset during the scan of J at (0,0), while cell (2,1) is being read.
        in_x  = '0;
        in_y  = '0;
        t_id  = 3'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_reset_rd_en", {31'b0, rd_en}, 32'd1);
        chk("pre_reset_rd_x", {27'b0, rd_x}, 32'd2);
        chk("pre_reset_rd_y", {27'b0, rd_y}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rd_en", {31'b0, rd_en}, 32'd0);
        chk("async_done", {31'b0, done}, 32'd0);
        chk("async_rd_x", {27'b0, rd_x}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("idle_after_reset_rd_en", {31'b0, rd_en}, 32'd0);

        // A fresh check after reset completes normally.
        do_check(0, 0, 6, 1'b0, 4, 160'({pk(2,1), pk(1,1), pk(0,1), pk(0,0)}), 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
